// File: rtl/dense_weight_streamer.sv
// dense_weight_streamer: sequences one activation-stationary dot-product pass
// for a dense-layer MAC array. Each accepted activation triggers a read of one
// weight row; one cycle later the activation, the returned row, en_o and
// accumulate_o are presented to the array. After the last step the streamer
// waits for the array pipeline to drain and then pulses done_o.
module dense_weight_streamer #(
    parameter int N           = 16,
    parameter int EngineCount = 16,
    parameter int AddrW       = 16,
    parameter int MacLatency  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [15:0]                       input_count_i,
    input  logic [AddrW-1:0]                  weight_base_i,
    input  logic                              act_valid_i,
    input  logic [N-1:0]                      act_data_i,
    output logic                              act_ready_o,
    output logic                              mem_rd_o,
    output logic [AddrW-1:0]                  mem_addr_o,
    input  logic [EngineCount*N-1:0]          mem_data_i,
    output logic [EngineCount-1:0][N-1:0]     value_o,
    output logic [EngineCount-1:0][N-1:0]     weight_o,
    output logic                              en_o,
    output logic                              accumulate_o,
    output logic                              busy_o,
    output logic                              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Drain length: a non-empty pass waits for its last issue cycle plus
    // MacLatency; an empty pass has no issue cycle, so it waits one less.
    localparam int DW = $clog2(MacLatency + 2);
    localparam logic [DW-1:0] DRAIN_RUN   = DW'(MacLatency);
    localparam logic [DW-1:0] DRAIN_EMPTY = DW'((MacLatency > 0) ? (MacLatency - 1) : 0);

    state_t                          state;
    state_t                          state_next;
    logic [15:0]                     cnt;
    logic [15:0]                     issued;
    logic [AddrW-1:0]                addr;
    logic [DW-1:0]                   drain;
    logic                            handshake;
    logic                            issue_q;
    logic                            acc_q;
    logic [N-1:0]                    act_stage;
    logic [EngineCount-1:0][N-1:0]   weight_hold;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (input_count_i == 16'd0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (handshake && ((issued + 16'd1) == cnt)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control outputs: stream ready, weight read strobe/address, status
    always_comb begin
        act_ready_o = (state == RUN) && (issued != cnt);
        handshake   = act_ready_o && act_valid_i;
        mem_rd_o    = handshake;
        mem_addr_o  = handshake ? (addr + AddrW'(issued)) : '0;
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
    end

    // Pass bookkeeping: latched count/base, step counter, drain countdown
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            addr   <= '0;
            issued <= '0;
            drain  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drain <= DRAIN_EMPTY;
                    if (start_i) begin
                        cnt    <= input_count_i;
                        addr   <= weight_base_i;
                        issued <= '0;
                    end
                end
                RUN: begin
                    drain <= DRAIN_RUN;
                    if (handshake) begin
                        issued <= issued + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain != '0) begin
                        drain <= drain - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Issue stage: activation and first-step flag registered with the read,
    // presented alongside the returning weight row one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_q     <= 1'b0;
            acc_q       <= 1'b0;
            act_stage   <= '0;
            weight_hold <= '0;
        end else begin
            issue_q     <= handshake;
            weight_hold <= weight_o;
            if (handshake) begin
                act_stage <= act_data_i;
                acc_q     <= (issued != 16'd0);
            end
        end
    end

    // Array-facing outputs; weights pass straight from memory on issue cycles
    // and otherwise hold the last row presented
    always_comb begin
        en_o         = issue_q;
        accumulate_o = acc_q;
        weight_o     = issue_q ? mem_data_i : weight_hold;
        for (int unsigned i = 0; i < EngineCount; i++) begin
            value_o[i] = act_stage;
        end
    end

endmodule

// File: tb/tb_dense_weight_streamer.sv
// Scoreboard bench for dense_weight_streamer: the driver pushes expected steps
// and read addresses when a pass is issued; a negedge monitor pops and compares
// whenever the DUT presents a read, an enabled step or done.
module tb_dense_weight_streamer;

    localparam int N  = 16;
    localparam int EC = 16;
    localparam int AW = 16;
    localparam int ML = 1;

    typedef struct {
        logic [15:0] act;
        logic [15:0] addr;
        logic        acc;
    } step_t;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    start_i = 1'b0;
    logic [15:0]             input_count = '0;
    logic [AW-1:0]           weight_base = '0;
    logic                    act_valid = 1'b0;
    logic [N-1:0]            act_data = '0;
    logic                    act_ready;
    logic                    mem_rd;
    logic [AW-1:0]           mem_addr;
    logic [EC*N-1:0]         mem_data = '0;
    logic [EC-1:0][N-1:0]    value;
    logic [EC-1:0][N-1:0]    weight;
    logic                    en;
    logic                    accumulate;
    logic                    busy;
    logic                    done;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    ref_cyc = 0;
    int    exp_gap = 0;
    bit    pass_active = 1'b0;
    bit    mon_on = 1'b0;

    step_t       exp_steps[$];
    logic [15:0] exp_addr[$];
    logic [15:0] dir_acts[$];

    logic [255:0] last_value = '0;
    logic [255:0] last_weight = '0;
    logic         last_acc = 1'b0;

    dense_weight_streamer #(
        .N(N),
        .EngineCount(EC),
        .AddrW(AW),
        .MacLatency(ML)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .input_count_i(input_count),
        .weight_base_i(weight_base),
        .act_valid_i(act_valid),
        .act_data_i(act_data),
        .act_ready_o(act_ready),
        .mem_rd_o(mem_rd),
        .mem_addr_o(mem_addr),
        .mem_data_i(mem_data),
        .value_o(value),
        .weight_o(weight),
        .en_o(en),
        .accumulate_o(accumulate),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Deterministic weight content for any row address
    function automatic logic [255:0] row(input logic [15:0] a);
        logic [255:0] r;
        logic [15:0]  t;
        r = '0;
        for (int i = 0; i < EC; i++) begin
            t = a * 16'h9E37;
            r[i*16 +: 16] = (t + 16'(i * 523)) ^ 16'hA5C3;
        end
        return r;
    endfunction

    function automatic logic [255:0] bcast(input logic [15:0] v);
        logic [255:0] r;
        for (int i = 0; i < EC; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    // Synchronous weight memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd) mem_data <= row(mem_addr);
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read/step/done
    always @(negedge clk) begin
        step_t s;
        if (mon_on) begin
            if (start_i && !busy) ref_cyc = cyc;
            if (act_valid && act_ready) ref_cyc = cyc;
            if (act_ready) check("ready_with_pending", 256'(exp_addr.size() != 0), 256'(1));
            if (mem_rd) begin
                if (exp_addr.size() == 0) begin
                    check("spurious_read", 256'(mem_addr), 256'(1'bx));
                end else begin
                    check("read_addr", 256'(mem_addr), 256'(exp_addr.pop_front()));
                end
            end
            if (en) begin
                if (exp_steps.size() == 0) begin
                    check("spurious_en", 256'(en), 256'(0));
                end else begin
                    s = exp_steps.pop_front();
                    check("value", value, bcast(s.act));
                    check("weight", weight, row(s.addr));
                    check("accumulate", 256'(accumulate), 256'(s.acc));
                    last_value  = bcast(s.act);
                    last_weight = row(s.addr);
                    last_acc    = s.acc;
                end
            end else begin
                check("value_hold", value, last_value);
                check("weight_hold", weight, last_weight);
                check("acc_hold", 256'(accumulate), 256'(last_acc));
            end
            if (done) begin
                if (!pass_active) begin
                    check("spurious_done", 256'(done), 256'(0));
                end else begin
                    check("done_timing", 256'(cyc - ref_cyc), 256'(exp_gap));
                    pass_active = 1'b0;
                end
            end
            if (rst_i) begin
                last_value  = '0;
                last_weight = '0;
                last_acc    = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_en"}, 256'(en), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_ready"}, 256'(act_ready), 256'(0));
        check({tag, "_rd"}, 256'(mem_rd), 256'(0));
        check({tag, "_addr"}, 256'(mem_addr), 256'(0));
        check({tag, "_acc"}, 256'(accumulate), 256'(0));
        check({tag, "_value"}, value, 256'(0));
        check({tag, "_weight"}, weight, 256'(0));
    endtask

    // One pass; entered and left at posedge+1
    task automatic do_pass(input int count, input logic [15:0] base, input int stall_k,
                           input bit rand_stall, input bit inject, input int abort_k);
        logic [15:0] acts[$];
        step_t       s;
        int          t;
        int          n;
        for (int k = 0; k < count; k++) begin
            if (dir_acts.size() > 0) acts.push_back(dir_acts.pop_front());
            else acts.push_back(16'($urandom));
            s.act  = acts[k];
            s.addr = base + 16'(k);
            s.acc  = (k != 0);
            exp_steps.push_back(s);
            exp_addr.push_back(s.addr);
        end
        exp_gap     = (count == 0) ? (ML + 1) : (ML + 2);
        pass_active = 1'b1;
        start_i     = 1'b1;
        input_count = 16'(count);
        weight_base = base;
        act_valid   = (count == 0);
        @(posedge clk); #1;
        start_i     = 1'b0;
        input_count = 16'($urandom);
        weight_base = 16'($urandom);
        for (int k = 0; k < count; k++) begin
            act_data  = acts[k];
            act_valid = 1'b1;
            if (inject && k == 1) begin
                start_i     = 1'b1;
                input_count = 16'd9;
                weight_base = 16'h4000;
            end
            t = 0;
            while (!act_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!act_ready) begin
                fail_now("act_ready");
                break;
            end
            if (abort_k != 0 && k == abort_k) begin
                rst_i = 1'b1;
                @(posedge clk); #1;
                rst_i     = 1'b0;
                act_valid = 1'b0;
                #1;
                check_all_zero("abort");
                exp_steps.delete();
                exp_addr.delete();
                pass_active = 1'b0;
                @(posedge clk); #1;
                check("abort_no_en", 256'(en), 256'(0));
                repeat (4) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk); #1;
            start_i   = 1'b0;
            act_valid = 1'b0;
            act_data  = 16'($urandom);
            n = 0;
            if (k == stall_k) n = 2;
            else if (rand_stall && $urandom_range(0, 3) > 1) n = $urandom_range(1, 2);
            repeat (n) begin
                @(posedge clk); #1;
            end
        end
        t = 0;
        while (pass_active && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        act_valid = 1'b0;
        if (pass_active) begin
            fail_now("done");
            pass_active = 1'b0;
        end
        check("steps_left", 256'(exp_steps.size()), 256'(0));
        check("reads_left", 256'(exp_addr.size()), 256'(0));
        exp_steps.delete();
        exp_addr.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check_all_zero("reset");
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Back-to-back 5, -2, 7 from base 0x0010
        dir_acts = {16'd5, 16'hFFFE, 16'd7};
        do_pass(3, 16'h0010, -1, 1'b0, 1'b0, 0);
        // Same with a two-cycle stall after the second step
        dir_acts = {16'd5, 16'hFFFE, 16'd7};
        do_pass(3, 16'h0010, 1, 1'b0, 1'b0, 0);
        // Empty pass with act_valid held high
        do_pass(0, 16'h1234, -1, 1'b0, 1'b0, 0);
        // Address wrap
        do_pass(4, 16'hFFFE, -1, 1'b0, 1'b0, 0);
        // Reset coinciding with the third handshake of a five-step pass
        do_pass(5, 16'h0200, -1, 1'b0, 1'b0, 2);
        do_pass(3, 16'h0300, -1, 1'b0, 1'b0, 0);
        // Start pulsed mid-run is ignored
        do_pass(4, 16'h0500, -1, 1'b0, 1'b1, 0);
        // Randomized passes, back-to-back after done
        for (int p = 0; p < 25; p++) begin
            do_pass($urandom_range(0, 10), 16'($urandom), -1, 1'b1, p[0], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
